// File: rtl/cpu_mem_pkg.sv
// Shared types for the fetch/MEM-stage memory port arbiter.
package cpu_mem_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_D = 3'd1,
        BUSY_I = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } arb_state_t;

    // Which requester owned the most recent access.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Cycles from the access strobe to captured read data.
    localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times one fixed-latency memory access.
// Loading sets it to MAX; it counts down to zero and then rests there.
// `last` is high while the count is 1, i.e. on the edge that ends the access.
module arb_lat_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    // Count register: load wins, otherwise count down while non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(MAX);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// the MEM pipeline stage, and produces the pipeline stall.
//
// Handshake: a requester raises its request (if_req, or d_rmem/d_wmem) and
// holds it, with address/data stable, until its one-cycle valid pulse
// (if_valid / d_valid); the read data is valid in that same cycle. A request
// that drops while its access is in flight still completes and still pulses
// valid. Grants are only issued from IDLE, so a request held across the
// DONE cycle is treated as a new request one cycle later.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rmem,
    input  logic              d_wmem,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    arb_state_t state, state_n;
    grant_t     last_grant;
    logic       d_req;
    logic       grant_d;
    logic       grant_i;
    logic       cnt_last;
    logic       op_store;

    // Both load and store set means store; the illegal combination is not rejected.
    assign d_req = d_rmem | d_wmem;

    arb_lat_counter #(
        .MAX (MEM_LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (grant_d | grant_i),
        .last (cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and grant decision; contention alternates against last_grant.
    always_comb begin
        state_n = state;
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || last_grant == FETCH)) begin
                    grant_d = 1'b1;
                    state_n = BUSY_D;
                end else if (if_req) begin
                    grant_i = 1'b1;
                    state_n = BUSY_I;
                end
            end
            BUSY_D:  if (cnt_last) state_n = DONE_D;
            BUSY_I:  if (cnt_last) state_n = DONE_I;
            DONE_D:  state_n = IDLE;
            DONE_I:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory-side registers, grant history and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            d_rdata    <= '0;
            if_rdata   <= '0;
            op_store   <= 1'b0;
            last_grant <= FETCH;
        end else begin
            mem_en <= grant_d | grant_i;
            mem_we <= grant_d & d_wmem;
            if (grant_d) begin
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                op_store   <= d_wmem;
                last_grant <= DATA;
            end else if (grant_i) begin
                mem_addr   <= if_addr;
                op_store   <= 1'b0;
                last_grant <= FETCH;
            end
            if (state == BUSY_D && cnt_last && !op_store) begin
                d_rdata <= mem_rdata;
            end
            if (state == BUSY_I && cnt_last) begin
                if_rdata <= mem_rdata;
            end
        end
    end

    assign d_valid   = (state == DONE_D);
    assign if_valid  = (state == DONE_I);
    assign stall     = d_req & (state != DONE_D);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector tables for a MEM_LAT=2 and a
// MEM_LAT=1 instance, plus a hand-written reset-in-flight sequence.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam logic [31:0] CAFE = 32'hCAFEF00D;
  localparam logic [31:0] A5   = 32'hA5A5A5A5;
  localparam logic [31:0] BAD  = 32'h0BADC0DE;
  localparam logic [31:0] F1   = 32'h11111111;
  localparam logic [31:0] F2   = 32'h22222222;
  localparam logic [31:0] ST1  = 32'h12345678;
  localparam logic [31:0] ST2  = 32'hFEEDFACE;
  localparam logic [31:0] ST3  = 32'h600DF00D;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance
  logic        if_req, if_valid, d_rmem, d_wmem, d_valid, stall, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  // MEM_LAT=1 instance
  logic        if_req1, if_valid1, d_rmem1, d_wmem1, d_valid1, stall1, mem_en1, mem_we1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [2:0]  dbg_state1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .d_rmem(d_rmem), .d_wmem(d_wmem), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
    .if_valid(if_valid1), .d_rmem(d_rmem1), .d_wmem(d_wmem1), .d_addr(d_addr1),
    .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_valid(d_valid1), .stall(stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .dbg_state(dbg_state1)
  );

  // Memory model, latency 2: data is presented only in the cycle after the
  // strobe cycle, junk otherwise, so a wrong capture edge shows up.
  logic [31:0] mem0 [256];
  logic        en_d1 = 1'b0;
  logic [31:0] aq = 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 32'h0;
      mem0[8'h10] <= CAFE;
      mem0[8'h11] <= A5;
      mem0[8'h12] <= BAD;
      mem0[8'h40] <= F1;
      mem0[8'h41] <= F2;
    end else if (mem_en && mem_we) begin
      mem0[mem_addr[9:2]] <= mem_wdata;
    end
    en_d1 <= mem_en;
    if (mem_en) aq <= mem_addr;
  end
  assign mem_rdata = en_d1 ? mem0[aq[9:2]] : JUNK;

  // Memory model, latency 1: data is presented during the strobe cycle only.
  logic [31:0] mem1 [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'h0;
    end else if (mem_en1 && mem_we1) begin
      mem1[mem_addr1[9:2]] <= mem_wdata1;
    end
  end
  assign mem_rdata1 = mem_en1 ? mem1[mem_addr1[9:2]] : JUNK;

  // vector record: inputs for one cycle plus the outputs expected in it
  typedef struct {
    logic rm, wm, ir;
    logic [31:0] da, wd, ia;
    logic [2:0] st;
    logic stall, en, we, dv, iv;
    logic [31:0] ma, mw, drd, ird;
  } vec_t;

  vec_t tbl0[$];
  vec_t tbl1[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic rm, wm, ir, input logic [31:0] da, wd, ia,
                              input logic [2:0] st, input logic s, en, we, dv, iv,
                              input logic [31:0] ma, mw, drd, ird);
    vec_t v;
    v.rm = rm; v.wm = wm; v.ir = ir; v.da = da; v.wd = wd; v.ia = ia;
    v.st = st; v.stall = s; v.en = en; v.we = we; v.dv = dv; v.iv = iv;
    v.ma = ma; v.mw = mw; v.drd = drd; v.ird = ird;
    return v;
  endfunction

  function automatic logic [135:0] expv(input vec_t v);
    return {v.st, v.stall, v.en, v.we, v.dv, v.iv, v.ma, v.mw, v.drd, v.ird};
  endfunction

  // address only compared when a strobe is expected, write data only on stores
  function automatic logic [135:0] obs0(input vec_t v);
    return {dbg_state, stall, mem_en, mem_we, d_valid, if_valid,
            v.en ? mem_addr : 32'h0, v.we ? mem_wdata : 32'h0, d_rdata, if_rdata};
  endfunction

  function automatic logic [135:0] obs1(input vec_t v);
    return {dbg_state1, stall1, mem_en1, mem_we1, d_valid1, if_valid1,
            v.en ? mem_addr1 : 32'h0, v.we ? mem_wdata1 : 32'h0, d_rdata1, if_rdata1};
  endfunction

  function automatic logic [135:0] raw0();
    return {dbg_state, stall, mem_en, mem_we, d_valid, if_valid, mem_addr, mem_wdata, d_rdata, if_rdata};
  endfunction

  function automatic logic [135:0] raw1();
    return {dbg_state1, stall1, mem_en1, mem_we1, d_valid1, if_valid1, mem_addr1, mem_wdata1, d_rdata1, if_rdata1};
  endfunction

  // scoreboard compare
  task automatic check(input string nm, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input vec_t v);
    d_rmem = v.rm; d_wmem = v.wm; if_req = v.ir;
    d_addr = v.da; d_wdata = v.wd; if_addr = v.ia;
  endtask

  task automatic drive1(input vec_t v);
    d_rmem1 = v.rm; d_wmem1 = v.wm; if_req1 = v.ir;
    d_addr1 = v.da; d_wdata1 = v.wd; if_addr1 = v.ia;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rm wm ir  daddr   wdata  iaddr |  state  stl en we dv iv  maddr  mwdata drdata idata
    // load 0x40
    tbl0.push_back(mk(1,0,0,'h40,0,0,      IDLE,  1,0,0,0,0, 0,   0,   0,    0));
    tbl0.push_back(mk(1,0,0,'h40,0,0,      BUSY_D,1,1,0,0,0, 'h40,0,   0,    0));
    tbl0.push_back(mk(1,0,0,'h40,0,0,      BUSY_D,1,0,0,0,0, 0,   0,   0,    0));
    tbl0.push_back(mk(1,0,0,'h40,0,0,      DONE_D,0,0,0,1,0, 0,   0,   CAFE, 0));
    tbl0.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   CAFE, 0));
    // store 0x80
    tbl0.push_back(mk(0,1,0,'h80,ST1,0,    IDLE,  1,0,0,0,0, 0,   0,   CAFE, 0));
    tbl0.push_back(mk(0,1,0,'h80,ST1,0,    BUSY_D,1,1,1,0,0, 'h80,ST1, CAFE, 0));
    tbl0.push_back(mk(0,1,0,'h80,ST1,0,    BUSY_D,1,0,0,0,0, 0,   0,   CAFE, 0));
    tbl0.push_back(mk(0,1,0,'h80,ST1,0,    DONE_D,0,0,0,1,0, 0,   0,   CAFE, 0));
    // lone fetch 0x104 (leaves last grant = fetch)
    tbl0.push_back(mk(0,0,1,0,0,'h104,     IDLE,  0,0,0,0,0, 0,   0,   CAFE, 0));
    tbl0.push_back(mk(0,0,1,0,0,'h104,     BUSY_I,0,1,0,0,0, 'h104,0,  CAFE, 0));
    tbl0.push_back(mk(0,0,1,0,0,'h104,     BUSY_I,0,0,0,0,0, 0,   0,   CAFE, 0));
    tbl0.push_back(mk(0,0,1,0,0,'h104,     DONE_I,0,0,0,0,1, 0,   0,   CAFE, F2));
    // contention: data, fetch, data
    tbl0.push_back(mk(1,0,1,'h44,0,'h100,  IDLE,  1,0,0,0,0, 0,   0,   CAFE, F2));
    tbl0.push_back(mk(1,0,1,'h44,0,'h100,  BUSY_D,1,1,0,0,0, 'h44,0,   CAFE, F2));
    tbl0.push_back(mk(1,0,1,'h44,0,'h100,  BUSY_D,1,0,0,0,0, 0,   0,   CAFE, F2));
    tbl0.push_back(mk(1,0,1,'h44,0,'h100,  DONE_D,0,0,0,1,0, 0,   0,   A5,   F2));
    tbl0.push_back(mk(1,0,1,'h48,0,'h100,  IDLE,  1,0,0,0,0, 0,   0,   A5,   F2));
    tbl0.push_back(mk(1,0,1,'h48,0,'h100,  BUSY_I,1,1,0,0,0, 'h100,0,  A5,   F2));
    tbl0.push_back(mk(1,0,1,'h48,0,'h100,  BUSY_I,1,0,0,0,0, 0,   0,   A5,   F2));
    tbl0.push_back(mk(1,0,1,'h48,0,'h100,  DONE_I,1,0,0,0,1, 0,   0,   A5,   F1));
    tbl0.push_back(mk(1,0,1,'h48,0,'h104,  IDLE,  1,0,0,0,0, 0,   0,   A5,   F1));
    tbl0.push_back(mk(1,0,1,'h48,0,'h104,  BUSY_D,1,1,0,0,0, 'h48,0,   A5,   F1));
    tbl0.push_back(mk(1,0,1,'h48,0,'h104,  BUSY_D,1,0,0,0,0, 0,   0,   A5,   F1));
    tbl0.push_back(mk(1,0,1,'h48,0,'h104,  DONE_D,0,0,0,1,0, 0,   0,   BAD,  F1));
    // load held through DONE_D: no strobe until after the next IDLE cycle
    tbl0.push_back(mk(1,0,0,'h48,0,0,      IDLE,  1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h48,0,0,      BUSY_D,1,1,0,0,0, 'h48,0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h48,0,0,      BUSY_D,1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h48,0,0,      DONE_D,0,0,0,1,0, 0,   0,   BAD,  F1));
    // rmem and wmem together -> store
    tbl0.push_back(mk(1,1,0,'h84,ST2,0,    IDLE,  1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,1,0,'h84,ST2,0,    BUSY_D,1,1,1,0,0, 'h84,ST2, BAD,  F1));
    tbl0.push_back(mk(1,1,0,'h84,ST2,0,    BUSY_D,1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,1,0,'h84,ST2,0,    DONE_D,0,0,0,1,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   BAD,  F1));
    // read back the first store
    tbl0.push_back(mk(1,0,0,'h80,0,0,      IDLE,  1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h80,0,0,      BUSY_D,1,1,0,0,0, 'h80,0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h80,0,0,      BUSY_D,1,0,0,0,0, 0,   0,   BAD,  F1));
    tbl0.push_back(mk(1,0,0,'h80,0,0,      DONE_D,0,0,0,1,0, 0,   0,   ST1,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   ST1,  F1));
    // request dropped while in flight still completes
    tbl0.push_back(mk(1,0,0,'h84,0,0,      IDLE,  1,0,0,0,0, 0,   0,   ST1,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         BUSY_D,0,1,0,0,0, 'h84,0,   ST1,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         BUSY_D,0,0,0,0,0, 0,   0,   ST1,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         DONE_D,0,0,0,1,0, 0,   0,   ST2,  F1));
    tbl0.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   ST2,  F1));

    // MEM_LAT=1 instance: illegal rmem+wmem store, then load it back
    tbl1.push_back(mk(1,1,0,'h20,ST3,0,    IDLE,  1,0,0,0,0, 0,   0,   0,    0));
    tbl1.push_back(mk(1,1,0,'h20,ST3,0,    BUSY_D,1,1,1,0,0, 'h20,ST3, 0,    0));
    tbl1.push_back(mk(1,1,0,'h20,ST3,0,    DONE_D,0,0,0,1,0, 0,   0,   0,    0));
    tbl1.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   0,    0));
    tbl1.push_back(mk(1,0,0,'h20,0,0,      IDLE,  1,0,0,0,0, 0,   0,   0,    0));
    tbl1.push_back(mk(1,0,0,'h20,0,0,      BUSY_D,1,1,0,0,0, 'h20,0,   0,    0));
    tbl1.push_back(mk(1,0,0,'h20,0,0,      DONE_D,0,0,0,1,0, 0,   0,   ST3,  0));
    tbl1.push_back(mk(0,0,0,0,0,0,         IDLE,  0,0,0,0,0, 0,   0,   ST3,  0));

    // reset
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_rmem = 0; d_wmem = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; if_addr1 = 0; d_rmem1 = 0; d_wmem1 = 0; d_addr1 = 0; d_wdata1 = 0;
    tick();
    tick();
    check("reset_lat2", raw0(), 136'h0);
    check("reset_lat1", raw1(), 136'h0);
    rst = 1'b0;

    // main table, MEM_LAT=2
    for (int i = 0; i < tbl0.size(); i++) begin
      drive0(tbl0[i]);
      #1;
      check($sformatf("lat2_vec%0d", i), obs0(tbl0[i]), expv(tbl0[i]));
      tick();
    end

    // reset while a load is in flight
    d_rmem = 1; d_addr = 32'h40;
    tick();
    #1;
    check("rst_pre_busy", 136'({dbg_state, mem_en, mem_addr}), 136'({BUSY_D, 1'b1, 32'h40}));
    rst = 1'b1;
    d_rmem = 0; d_addr = 0;
    tick();
    #1;
    check("rst_mid_access", raw0(), 136'h0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rst_stale%0d", i), 136'({dbg_state, d_valid, mem_en}), 136'({IDLE, 1'b0, 1'b0}));
      tick();
    end

    // MEM_LAT=1 table
    for (int i = 0; i < tbl1.size(); i++) begin
      drive1(tbl1[i]);
      #1;
      check($sformatf("lat1_vec%0d", i), obs1(tbl1[i]), expv(tbl1[i]));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
